// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream and writes it as 32-bit little-endian
// instruction words into instruction memory starting at BASE_ADDR, stalling
// the core while loading.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit checksum byte (sum of all data bytes modulo 256) after the last word.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_stall,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [1:0]  byte_idx_reg;
  logic [23:0] word_reg;        // bytes 0..2 of the word being assembled
  logic [15:0] cnt_reg;         // words still to be written, including current
  logic [31:0] addr_reg;        // address of the next word to write
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        error_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_reg;
`endif

  // start request classification (only meaningful in IDLE)
  logic        start_zero;
  logic        start_big;
  logic        last_byte;
  assign start_zero = (word_count == 16'd0);
  assign start_big  = ({16'd0, word_count} > MAX_W);
  assign last_byte  = in_valid && (byte_idx_reg == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !start_big) state_next = start_zero ? DONE : LOAD;
      end
      LOAD: begin
        if (last_byte) state_next = WRITE;
      end
      WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_next = (cnt_reg == 16'd1) ? CHECK : LOAD;
`else
        state_next = (cnt_reg == 16'd1) ? DONE : LOAD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (in_valid) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      WRITE: begin mem_we   = 1'b1; busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin in_ready = 1'b1; busy = 1'b1; end
`endif
      DONE:  begin done     = 1'b1; busy = 1'b1; end
      default: ;
    endcase
    core_stall = busy;
  end

  // Datapath: byte packing, address/count tracking, write port and error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx_reg  <= 2'd0;
      word_reg      <= 24'd0;
      cnt_reg       <= 16'd0;
      addr_reg      <= BASE_ADDR;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= 32'd0;
      error_reg     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_reg       <= 8'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && start_big) begin
            error_reg <= 1'b1;
          end else if (start && !start_zero) begin
            error_reg    <= 1'b0;
            addr_reg     <= BASE_ADDR;
            byte_idx_reg <= 2'd0;
            word_reg     <= 24'd0;
            cnt_reg      <= word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= 8'd0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= sum_reg + in_byte;
`endif
            case (byte_idx_reg)
              2'd0: word_reg[7:0]   <= in_byte;
              2'd1: word_reg[15:8]  <= in_byte;
              2'd2: word_reg[23:16] <= in_byte;
              default: begin
                // 4th byte completes the word: latch the write port now so
                // address/data stay stable through and after the write cycle
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= {in_byte, word_reg};
              end
            endcase
          end
        end
        WRITE: begin
          addr_reg <= addr_reg + 32'd4;
          cnt_reg  <= cnt_reg - 16'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (in_valid && (in_byte != sum_reg)) error_reg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven directed loads, reset corner
// cases, a maximum-length load and randomized loads checked against a
// word-list reference model. Honors IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, core_stall, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_stall(core_stall), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write/done monitor, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("reset_mem_addr", mem_addr, BASE);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
    end else if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end else begin
      chk("hold_mem_addr", mem_addr, prev_addr);
      chk("hold_mem_wdata", mem_wdata, prev_data);
    end
    prev_addr = mem_addr;
    prev_data = mem_wdata;
    if (done === 1'b1) done_cnt++;
  end

  // Reference model: word i is bytes 4i..4i+3, little-endian
  function automatic logic [31:0] model_word(input logic [7:0] q[$], input int i);
    return {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
  endfunction

  function automatic logic [7:0] model_sum(input logic [7:0] q[$]);
    logic [7:0] s = 8'd0;
    foreach (q[k]) s = s + q[k];
    return s;
  endfunction

  // Drive bytes; mode 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps
  task automatic feed(input logic [7:0] bq[$], input int mode);
    int i = 0;
    int cyc = 0;
    while (i < bq.size() && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if ((mode == 1 && cyc[0] == 1'b0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_byte  = bq[i];
        if (in_ready === 1'b1) i++;
      end
    end
    chk("feed_complete", (i == bq.size()) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input int wc, input logic [7:0] data[$], input int mode,
                          input logic [7:0] ck);
    logic [7:0] bq[$];
    int cyc = 0;
    logic exp_busy;
    bq = data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (wc >= 1 && wc <= MAXW) bq.push_back(ck);
`else
    if (ck == 8'hFF && wc < 0) bq.push_back(ck);
`endif
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    word_count = wc[15:0];
    @(negedge clk);
    start = 1'b0;
    word_count = 16'($urandom);
    exp_busy = (wc <= MAXW);
    chk($sformatf("busy_after_start wc=%0d", wc), busy, exp_busy);
    chk($sformatf("core_stall_after_start wc=%0d", wc), core_stall, exp_busy);
    chk($sformatf("done_after_start wc=%0d", wc), done, (wc == 0));
    if (bq.size() > 0) feed(bq, mode);
    while (busy !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("load_finished_in_time", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b0);
    chk("core_stall_idle", core_stall, 1'b0);
    $display("load wc=%0d mode=%0d writes=%0d done_pulses=%0d error=%0b",
             wc, mode, wr_addr_q.size(), done_cnt, error);
  endtask

  task automatic check_model(input string tag, input logic [7:0] data[$], input int wc);
    chk({tag, "_nwrites"}, wr_addr_q.size(), wc);
    for (int i = 0; i < wc && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], model_word(data, i));
    end
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  typedef struct {
    int          wc;
    int          mode;
    logic [63:0] bytes;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
    int          ndone;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] q[$];
    vecs[0] = '{2,    0, 64'h0010_0093_0000_0013, 2, 32'h0000_0013, 32'h0010_0093, 1'b0, 1};
    vecs[1] = '{1,    1, 64'h0000_0000_DEAD_BEEF, 1, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[2] = '{0,    0, 64'h0,                   0, 32'h0,         32'h0,         1'b0, 1};
    vecs[3] = '{1025, 0, 64'h0,                   0, 32'h0,         32'h0,         1'b1, 0};
    vecs[4] = '{1,    2, 64'h0000_0000_1234_5678, 1, 32'h1234_5678, 32'h0,         1'b0, 1};

    // Reset held for two cycles: every output at its reset value
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_core_stall", core_stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    // Directed table
    for (int v = 0; v < 5; v++) begin
      q.delete();
      if (vecs[v].wc >= 1 && vecs[v].wc <= 2)
        for (int k = 0; k < 4 * vecs[v].wc; k++) q.push_back(vecs[v].bytes[8*k +: 8]);
      run_load(vecs[v].wc, q, vecs[v].mode, model_sum(q));
      chk($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), vecs[v].nwr);
      if (vecs[v].nwr >= 1 && wr_addr_q.size() >= 1) begin
        chk($sformatf("vec%0d_addr0", v), wr_addr_q[0], BASE);
        chk($sformatf("vec%0d_data0", v), wr_data_q[0], vecs[v].w0);
      end
      if (vecs[v].nwr >= 2 && wr_addr_q.size() >= 2) begin
        chk($sformatf("vec%0d_addr1", v), wr_addr_q[1], BASE + 32'd4);
        chk($sformatf("vec%0d_data1", v), wr_data_q[1], vecs[v].w1);
      end
      chk($sformatf("vec%0d_error", v), error, vecs[v].err);
      chk($sformatf("vec%0d_done", v), done_cnt, vecs[v].ndone);
    end

    // Reset in the middle of a word, then a fresh single-word load
    wr_addr_q.delete();
    @(negedge clk);
    start = 1'b1;
    word_count = 16'd1;
    @(negedge clk);
    start = 1'b0;
    q = '{8'hAA, 8'hBB};
    feed(q, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_core_stall", core_stall, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_error", error, 1'b0);
    chk("midrst_no_write", wr_addr_q.size(), 0);
    reset = 1'b1;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, q, 0, model_sum(q));
    chk("after_rst_nwrites", wr_addr_q.size(), 1);
    if (wr_addr_q.size() >= 1) begin
      chk("after_rst_addr", wr_addr_q[0], BASE);
      chk("after_rst_data", wr_data_q[0], 32'h4433_2211);
    end

    // Largest accepted word_count
    q.delete();
    for (int k = 0; k < 4 * MAXW; k++) q.push_back(8'($urandom));
    run_load(MAXW, q, 0, model_sum(q));
    check_model("maxw", q, MAXW);

    // Randomized loads against the reference model
    for (int t = 0; t < 15; t++) begin
      int wc;
      wc = $urandom_range(1, 5);
      q.delete();
      for (int k = 0; k < 4 * wc; k++) q.push_back(8'($urandom));
      run_load(wc, q, $urandom_range(0, 2), model_sum(q));
      check_model($sformatf("rand%0d", t), q, wc);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, q, 0, 8'h0A);
    chk("ck_good_error", error, 1'b0);
    chk("ck_good_done", done_cnt, 1);
    run_load(1, q, 0, 8'h0B);
    chk("ck_bad_error", error, 1'b1);
    chk("ck_bad_done", done_cnt, 1);
    chk("ck_bad_nwrites", wr_addr_q.size(), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word_count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low; state is cleared on a rising clk edge while reset=0.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 word_count  input  16  number of 32-bit instruction words to load; sampled with start.
REQ-007 in_byte  input  8  serial program byte stream.
REQ-008 in_valid  input  1  in_byte is valid.
REQ-009 in_ready  output  1  loader accepts in_byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  32  byte address of the write.
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 core_stall  output  1  holds the fetch PC and suppresses fetch while loading.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  single-cycle pulse at load completion.
REQ-016 error  output  1  sticky load error flag.

Function
REQ-017 The FSM states SHALL be IDLE, LOAD, WRITE, CHECK and DONE.
REQ-018 In IDLE, the outputs SHALL be in_ready=0, mem_we=0, busy=0 and core_stall=0.
REQ-019 Start in IDLE with 1<=word_count<=MAX_WORDS SHALL do all of the following:
- clear error;
- set the address to BASE_ADDR and the byte index to 0;
- enter LOAD on the next cycle.
REQ-020 Start with word_count=0 SHALL go to DONE without any memory write.
REQ-021 Start with word_count>MAX_WORDS SHALL set error=1, stay in IDLE and raise no done pulse.
REQ-022 Start SHALL be ignored in every state except IDLE.
REQ-023 In LOAD, in_ready=1, and a byte is accepted exactly when in_valid and in_ready are both 1.
REQ-024 Bytes SHALL be packed little-endian: the k-th accepted byte (k=0..3) goes to bits [8k+7:8k].
REQ-025 Acceptance of the 4th byte SHALL move the FSM to WRITE.
REQ-026 In WRITE, for exactly one cycle:
- mem_we=1, mem_addr=current address, mem_wdata=assembled word, in_ready=0;
- afterwards the address increments by 4 and the remaining-word count decrements.
REQ-027 After WRITE, the FSM SHALL return to LOAD if words remain; otherwise it goes to CHECK (macro defined) or DONE (macro undefined).
REQ-028 Cycles with in_valid=0 in LOAD SHALL stall progress without losing the partial word.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 busy and core_stall SHALL be 1 in LOAD, WRITE, CHECK and DONE.
REQ-031 mem_addr SHALL wrap modulo 2^32.
REQ-032 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-033 A reset asserted at any time, including mid-load, SHALL do all of the following on the next rising edge:
- FSM to IDLE;
- in_ready=0, mem_we=0, core_stall=0, busy=0, done=0, error=0;
- mem_addr=BASE_ADDR, mem_wdata=0;
- byte index, word counter and checksum cleared.
REQ-034 A load interrupted by reset SHALL NOT resume; any words already written remain in memory.

Configuration
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined:
- an 8-bit running sum modulo 256 of all data bytes SHALL be kept;
- CHECK SHALL assert in_ready=1 and accept one trailing checksum byte;
- a mismatch sets error=1;
- DONE follows whether or not the checksum matched.
REQ-036 With IMEM_LOADER_CHECKSUM_EN undefined:
- the CHECK state and the checksum logic SHALL be absent;
- error SHALL be set only by the word_count>MAX_WORDS rule.

Verification
REQ-037 Scenario: reset=0 for 2 cycles -> all outputs at their reset values and core_stall=0.
REQ-038 Scenario: start, word_count=2, bytes 13,00,00,00,93,00,10,00 sent back-to-back -> two writes:
- mem_wdata 32'h00000013 at mem_addr 0x0;
- mem_wdata 32'h00100093 at mem_addr 0x4;
- then done pulses once.
REQ-039 Scenario: word_count=1 with in_valid toggling every other cycle -> a single write of the correct word, with the stall cycles ignored.
REQ-040 Scenario: start with word_count=0 -> done pulse after 1 cycle and mem_we never 1.
REQ-041 Scenario: start with word_count=1025 -> error=1, busy=0, no done pulse.
REQ-042 Scenario: reset=0 after 2 of 4 bytes, then a new load of word_count=1 -> one write at BASE_ADDR with no stale bytes.
REQ-043 Scenario (macro defined): word_count=1, bytes 01,02,03,04, checksum 0x0A -> error=0; a checksum of 0x0B -> error=1 and done still pulses.
